// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and external memory signals
// around the shared memory port arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the single memory port.
// MEM_ARB_MISALIGN_TRAP_EN: trap misaligned data accesses.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_e;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_q, own_d;
    logic          we_q, we_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic        d_win;
    logic        d_half, d_word;
    logic [1:0]  d_off;
    logic        if_gnt_c, d_gnt_c;
    logic        if_rv_c, d_rv_c, err_c;
    logic        m_req_c;
    logic        q_byte, q_half;
    logic [31:0] shifted, ext;
    logic [3:0]  be_c;
    logic [31:0] wlane_c;
    logic        unused_addr;

    assign unused_addr = ^bus.if_addr[1:0];

    assign d_half = (bus.d_size[1:0] == 2'b01);
    assign d_word = bus.d_size[1];
    assign d_off  = d_word ? 2'b00 :
                    d_half ? {bus.d_addr[1], 1'b0} :
                    bus.d_addr[1:0];

    // Data wins unless a waiting fetch has hit the starvation limit
    assign d_win = bus.d_req &&
                   (!bus.if_req || (cnt_q < LIM));

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    logic d_mis;
    assign d_mis = (d_half && bus.d_addr[0]) ||
                   (d_word && (bus.d_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_d    = own_q;
        we_d     = we_q;
        size_d   = size_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if_rv_c  = 1'b0;
        d_rv_c   = 1'b0;
        err_c    = 1'b0;
        m_req_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_win) begin
                    d_gnt_c = 1'b1;
                    own_d   = 1'b1;
                    we_d    = bus.d_we;
                    size_d  = bus.d_size;
                    off_d   = d_off;
                    addr_d  = bus.d_addr[31:2];
                    wdata_d = bus.d_wdata;
                    if (!bus.if_req)
                        cnt_d = '0;
                    else if (cnt_q != LIM)
                        cnt_d = cnt_q + 1'b1;
                    state_d = REQ;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
                    if (d_mis)
                        state_d = ERR;
`endif
                end else if (bus.if_req) begin
                    if_gnt_c = 1'b1;
                    own_d    = 1'b0;
                    we_d     = 1'b0;
                    size_d   = 3'b010;
                    off_d    = 2'b00;
                    addr_d   = bus.if_addr[31:2];
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                m_req_c = 1'b1;
                if (bus.m_gnt)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_rvalid) begin
                    d_rv_c  = own_q;
                    if_rv_c = !own_q;
                    state_d = IDLE;
                end
            end
`ifdef MEM_ARB_MISALIGN_TRAP_EN
            ERR: begin
                d_rv_c  = 1'b1;
                err_c   = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign q_byte = (size_q[1:0] == 2'b00);
    assign q_half = (size_q[1:0] == 2'b01);

    always_comb begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
        unique case (1'b1)
            q_byte: begin
                be_c    = 4'b0001 << off_q;
                wlane_c = {4{wdata_q[7:0]}};
            end
            q_half: begin
                be_c    = 4'b0011 << {off_q[1], 1'b0};
                wlane_c = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = bus.m_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = shifted;
        unique case (1'b1)
            q_byte:
                ext = {{24{shifted[7] & ~size_q[2]}},
                       shifted[7:0]};
            q_half:
                ext = {{16{shifted[15] & ~size_q[2]}},
                       shifted[15:0]};
            default: ;
        endcase
    end

    // Gnt is combinational from IDLE, so mask it while reset is held
    assign bus.if_gnt    = if_gnt_c & rst_n;
    assign bus.d_gnt     = d_gnt_c & rst_n;
    assign bus.if_rvalid = if_rv_c;
    assign bus.if_rdata  = if_rv_c ? bus.m_rdata : '0;
    assign bus.d_rvalid  = d_rv_c;
    assign bus.d_rdata   = (d_rv_c && !we_q && !err_c) ?
                           ext : '0;
    assign bus.d_err     = err_c;

    assign bus.m_req   = m_req_c;
    assign bus.m_we    = m_req_c & we_q;
    assign bus.m_be    = m_req_c ? be_c : 4'b0000;
    assign bus.m_addr  = m_req_c ? {addr_q, 2'b00} : '0;
    assign bus.m_wdata = (m_req_c && we_q) ? wlane_c : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store requester. One transaction is in flight at a time. Data requests have priority over instruction fetches, and a starvation guard bounds how long fetch can be locked out. The block builds byte enables and aligned write lanes from the data-size code and address offset, and sign- or zero-extends load data before returning it. It sits between the fetch/LSU stages and the external memory interface.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through (≥1)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch address; bits [1:0] ignored
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid, one-cycle pulse
- if_rdata  out  32  fetch word, raw m_rdata
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (loads and stores), one-cycle pulse
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  misaligned-access error, qualifies d_rvalid
- m_req  out  1  memory request; held until m_gnt
- m_we  out  1  memory write
- m_be  out  4  byte enables
- m_addr  out  32  word address, bits [1:0] = 00
- m_wdata  out  32  lane-replicated write data
- m_gnt  in  1  memory accepted the request
- m_rvalid  in  1  memory response, reads and writes
- m_rdata  in  32  memory read word

## Operation
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE, arbitration:
  - If d_req and (!if_req or cnt < STARVE_LIMIT): grant data.
  - Else if if_req: grant fetch.
  - The chosen gnt is asserted combinationally. Owner, we, size, offset, word address and wdata are captured. Next state is REQ.
- REQ: m_req = 1, driven from the captured registers. On m_gnt, go to WAIT.
- WAIT: on m_rvalid, pulse the owner's rvalid and go to IDLE. m_rvalid in any other state is ignored.
- Starvation counter cnt:
  - On a data grant with if_req high: cnt increments, saturating at STARVE_LIMIT.
  - On a data grant with if_req low: cnt clears.
  - On a fetch grant: cnt clears.
- Fetch transactions: m_be = 1111, m_we = 0.
- Byte enables:
  - Byte: m_be = 0001 << addr[1:0].
  - Half: m_be = 0011 << {addr[1],0}.
  - Word: m_be = 1111.
  - Codes 011, 110 and 111 are treated as word.
- m_wdata:
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: wdata unchanged.
- Load return: m_rdata is shifted right by offset×8, then extended. B and H sign-extend from bit 7/15. BU and HU zero-extend.
- Reset is asynchronous: FSM goes to IDLE and cnt to 0. A response already in flight at reset is dropped.
- Reset values: every output is 0; gnt outputs are 0 during reset.

## Timing
- Request seen in IDLE at cycle 0: gnt at cycle 0, m_req from cycle 1.
- With m_gnt at cycle 1 and m_rvalid at cycle 2, rvalid is at cycle 2, passed through combinationally.
- Minimum transaction is 3 cycles. The next grant comes no earlier than the cycle after rvalid.
- Memory stalls: m_req and all m_* outputs stay stable in REQ until m_gnt. WAIT lasts an unbounded time.
- No grant is issued outside IDLE. Requesters hold req and its fields until gnt.

## Configuration
- MEM_ARB_MISALIGN_TRAP_EN defined:
  - A data request is misaligned if it is half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned request is granted, issues no memory access, and enters ERR for one cycle.
  - ERR: d_rvalid = 1, d_err = 1, d_rdata = 0. Then IDLE.
  - The request counts as a data grant for cnt.
- Not defined:
  - d_err is tied to 0.
  - Word accesses force the offset to 00.
  - Half accesses use addr[1] only.
  - No ERR state is built.

## Test plan
- Load byte: LB at 0x1003, m_rdata = 0x80AA_BBCC → m_be = 1000, m_addr = 0x1000, d_rdata = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- Store half: SH at 0x2002, d_wdata = 0x1234_BEEF → m_we = 1, m_be = 1100, m_wdata = 0xBEEF_BEEF, d_rvalid pulses with d_rdata = 0.
- Simultaneous request: if_req and d_req in the same cycle with cnt = 0 → d_gnt = 1, if_gnt = 0. The fetch is granted in the first IDLE after the data response.
- Starvation: d_req and if_req held continuously with STARVE_LIMIT = 4 → exactly 4 data grants, then 1 fetch grant, repeating.
- Misaligned word: LW at 0x3001 with the macro defined → d_gnt, m_req never asserted, next cycle d_rvalid = 1, d_err = 1. Without the macro → m_addr = 0x3000, m_be = 1111.
- Reset in flight: rst_n low during WAIT, then m_rvalid arrives after release → no rvalid output, FSM in IDLE, all outputs 0.
